// File: rtl/fifo_status.sv
// fifo_status: full/empty/fill flags and debug status for the FIFO.
//   Combinational: fifo_full, fifo_empty, fill. These come straight from
//                  wptr/rptr, so they add no latency to the pointer stages.
//   Registered:    almost_full, almost_empty, hwm (peak fill).
//   Sticky:        overflow (wr while full), underflow (rd while empty),
//                  ptr_err (fill > DEPTH); all cleared by clr_err.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   wptr, rptr         write/read pointers; MSB is the wrap bit
//   wr, rd             raw write/read request strobes
//   clr_err            sync clear of sticky flags; reloads hwm with current fill
//   fifo_full/empty    fill == DEPTH / fill == 0
//   fill               (wptr - rptr) mod 2**PTR_W
//   almost_full/empty  fill >= AF_LEVEL / fill <= AE_LEVEL, one cycle late
//   overflow, underflow, ptr_err, hwm   debug status
module fifo_status #(
  parameter int unsigned PTR_W    = 10,
  parameter int unsigned AF_LEVEL = 448,
  parameter int unsigned AE_LEVEL = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PTR_W-1:0] wptr,
  input  logic [PTR_W-1:0] rptr,
  input  logic             wr,
  input  logic             rd,
  input  logic             clr_err,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [PTR_W-1:0] fill,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic             ptr_err,
  output logic [PTR_W-1:0] hwm
);

  localparam logic [PTR_W-1:0] L_DEPTH = PTR_W'(2**(PTR_W-1));
  localparam logic [PTR_W-1:0] L_AF    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] L_AE    = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] w_fill;
  logic             w_full;
  logic             w_empty;
  logic             w_ptr_bad;

  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_ptr_err;
  logic [PTR_W-1:0] r_hwm;

  // Natural PTR_W-bit wrap keeps fill continuous across pointer wrap.
  assign w_fill    = wptr - rptr;
  assign w_full    = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                     (wptr[PTR_W-2:0] == rptr[PTR_W-2:0]);
  assign w_empty   = (wptr == rptr);
  assign w_ptr_bad = (w_fill > L_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_ptr_err      <= 1'b0;
      r_hwm          <= '0;
    end else begin
      r_almost_full  <= (w_fill >= L_AF);
      r_almost_empty <= (w_fill <= L_AE);
      // Set terms are OR'd after the clear so a same-cycle set wins.
      r_overflow     <= (r_overflow  & ~clr_err) | (wr & w_full);
      r_underflow    <= (r_underflow & ~clr_err) | (rd & w_empty);
      r_ptr_err      <= (r_ptr_err   & ~clr_err) | w_ptr_bad;
      // A corrupt fill must never pollute the peak, even on clr_err.
      if (!w_ptr_bad) begin
        if (clr_err)
          r_hwm <= w_fill;
        else if (w_fill > r_hwm)
          r_hwm <= w_fill;
      end
    end
  end

  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign fill         = w_fill;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign ptr_err      = r_ptr_err;
  assign hwm          = r_hwm;

endmodule

// File: tb/tb_fifo_status.sv
// Directed testbench for fifo_status with hand-computed expectations.
module tb_fifo_status;

  localparam int unsigned PTR_W = 10;

  logic             clk;
  logic             rst_n;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             wr;
  logic             rd;
  logic             clr_err;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W-1:0] fill;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic             ptr_err;
  logic [PTR_W-1:0] hwm;

  int unsigned n_checks;
  int unsigned n_fail;

  fifo_status #(
    .PTR_W    (PTR_W),
    .AF_LEVEL (448),
    .AE_LEVEL (64)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wptr         (wptr),
    .rptr         (rptr),
    .wr           (wr),
    .rd           (rd),
    .clr_err      (clr_err),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fill         (fill),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .ptr_err      (ptr_err),
    .hwm          (hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; return 1 ns after it so inputs change away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    wptr     = '0;
    rptr     = '0;
    wr       = 1'b0;
    rd       = 1'b0;
    clr_err  = 1'b0;
    #1 rst_n = 1'b0;
    #1;

    // 1. Reset state
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    chk("rst_perr", 32'(ptr_err), 0);
    chk("rst_hwm", 32'(hwm), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ae", 32'(almost_empty), 1);

    // 2. Full and overflow; concurrent read must not flag underflow
    wptr = 10'h200;
    rptr = 10'h000;
    settle();
    chk("full_flag", 32'(fifo_full), 1);
    chk("full_fill", 32'(fill), 512);
    chk("full_empty", 32'(fifo_empty), 0);
    wr = 1'b1;
    rd = 1'b1;
    tick();
    wr = 1'b0;
    rd = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_no_udf", 32'(underflow), 0);
    chk("full_af", 32'(almost_full), 1);
    chk("full_hwm", 32'(hwm), 512);
    chk("full_no_perr", 32'(ptr_err), 0);
    tick();
    chk("ovf_sticky", 32'(overflow), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // 3. Underflow with set-beats-clear
    wptr = 10'h155;
    rptr = 10'h155;
    rd   = 1'b1;
    settle();
    chk("udf_empty", 32'(fifo_empty), 1);
    tick();
    chk("udf_set", 32'(underflow), 1);
    clr_err = 1'b1;
    tick();
    chk("udf_set_wins", 32'(underflow), 1);
    rd = 1'b0;
    tick();
    clr_err = 1'b0;
    chk("udf_clr", 32'(underflow), 0);
    chk("clr_hwm_load", 32'(hwm), 0);
    chk("clr_ovf_stays0", 32'(overflow), 0);

    // 4. Wrapped pointers
    rptr = 10'h3F0;
    wptr = 10'h010;
    settle();
    chk("wrap_fill", 32'(fill), 32);
    chk("wrap_empty", 32'(fifo_empty), 0);
    chk("wrap_full", 32'(fifo_full), 0);
    tick();
    chk("wrap_ae", 32'(almost_empty), 1);
    chk("wrap_hwm", 32'(hwm), 32);
    // almost_empty drops one cycle after fill crosses 64
    rptr = 10'h000;
    wptr = 10'd65;
    settle();
    chk("ae_late_hold", 32'(almost_empty), 1);
    tick();
    chk("ae_late_drop", 32'(almost_empty), 0);

    // 5. almost_full sweep 447 -> 448 -> 447
    wptr = 10'd447;
    tick();
    chk("af_447", 32'(almost_full), 0);
    wptr = 10'd448;
    settle();
    chk("af_448_late", 32'(almost_full), 0);
    tick();
    chk("af_448", 32'(almost_full), 1);
    wptr = 10'd447;
    settle();
    chk("af_447_late", 32'(almost_full), 1);
    tick();
    chk("af_447_back", 32'(almost_full), 0);
    chk("sweep_hwm", 32'(hwm), 448);

    // 6. Pointer corruption, then async reset mid-cycle
    wptr = 10'h300;
    rptr = 10'h000;
    settle();
    chk("perr_fill", 32'(fill), 768);
    tick();
    chk("perr_set", 32'(ptr_err), 1);
    chk("perr_hwm_hold", 32'(hwm), 448);
    tick();
    chk("perr_sticky", 32'(ptr_err), 1);
    rst_n = 1'b0;
    settle();
    chk("async_perr", 32'(ptr_err), 0);
    chk("async_hwm", 32'(hwm), 0);
    chk("async_af", 32'(almost_full), 0);
    chk("async_ae", 32'(almost_empty), 1);
    wptr = '0;
    rptr = '0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
